// File: rtl/branch_predict_table.sv
// branch_predict_table: PC-indexed table of 2-bit saturating counters with an
// in-order FIFO of outstanding predictions. Lookups predict combinationally and
// push {index, prediction}; resolves pop the oldest entry, update its counter
// and raise a registered mispredict pulse.
// Counter encoding: 00 strong taken, 01 weak taken, 10 weak not-taken,
// 11 strong not-taken; predict taken iff counter[1] == 0.
// Optional macro BPT_GSHARE_EN: XOR the PC index with a non-speculative
// global history register updated on every accepted resolve.
module branch_predict_table #(
  parameter int INDEX_BITS = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int PC_WIDTH   = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          lookupValid_i,
  input  logic [PC_WIDTH-1:0]           fetchPc_i,
  output logic                          lookupReady_o,
  output logic                          predTaken_o,
  input  logic                          resolveValid_i,
  input  logic                          brTaken_i,
  input  logic                          flush_i,
  output logic                          mispredict_o,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding_o
);

  localparam int TABLE_SIZE = 1 << INDEX_BITS;
  localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(FIFO_DEPTH);

  logic [1:0]            ctr_q      [TABLE_SIZE];
  logic [INDEX_BITS-1:0] fifo_idx_q [FIFO_DEPTH];
  logic                  fifo_pred_q[FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_BITS:0]     count_q;
  logic                  mispredict_q;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_pred;
  logic [1:0]            head_ctr;
  logic [1:0]            next_ctr;
  logic                  full, empty, push, pop;

  assign pc_idx = fetchPc_i[INDEX_BITS+1:2];

  // Bits of the PC outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetchPc_i[PC_WIDTH-1:INDEX_BITS+2], fetchPc_i[1:0]};

`ifdef BPT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  assign lookup_idx = pc_idx ^ ghr_q;

  // Global history shifts in each accepted outcome; flush leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ghr_q <= '0;
    end else if (pop) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], brTaken_i};
    end
  end
`else
  assign lookup_idx = pc_idx;
`endif

  assign full          = (count_q == DEPTH_CNT);
  assign empty         = (count_q == '0);
  // A same-cycle pop frees the slot, so a full FIFO may still accept a lookup.
  assign lookupReady_o = ~full | resolveValid_i;
  assign push          = lookupValid_i & lookupReady_o & ~flush_i;
  assign pop           = resolveValid_i & ~empty;

  assign predTaken_o   = ~ctr_q[lookup_idx][1];
  assign head_idx      = fifo_idx_q[rd_ptr_q];
  assign head_pred     = fifo_pred_q[rd_ptr_q];
  assign head_ctr      = ctr_q[head_idx];
  assign mispredict_o  = mispredict_q;
  assign outstanding_o = count_q;

  // Saturating update of the resolving branch's counter.
  always_comb begin
    next_ctr = head_ctr;
    if (brTaken_i) begin
      if (head_ctr != 2'b00) next_ctr = head_ctr - 2'b01;
    end else begin
      if (head_ctr != 2'b11) next_ctr = head_ctr + 2'b01;
    end
  end

  // Counter table: cleared on reset, written only by an accepted resolve.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < TABLE_SIZE; i++) ctr_q[i] <= 2'b00;
    end else if (pop) begin
      ctr_q[head_idx] <= next_ctr;
    end
  end

  // FIFO payload storage; contents beyond the occupancy are don't-care.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= lookup_idx;
      fifo_pred_q[wr_ptr_q] <= predTaken_o;
    end
  end

  // FIFO pointers and occupancy; flush empties after the same-cycle pop.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= PTR_BITS'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_q <= PTR_BITS'(rd_ptr_q + 1'b1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered mispredict pulse following an accepted resolve.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= pop & (head_pred != brTaken_i);
    end
  end

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed self-checking bench for branch_predict_table.
module tb_branch_predict_table;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        lookupValid_i;
  logic [31:0] fetchPc_i;
  logic        lookupReady_o;
  logic        predTaken_o;
  logic        resolveValid_i;
  logic        brTaken_i;
  logic        flush_i;
  logic        mispredict_o;
  logic [3:0]  outstanding_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predict_table #(
    .INDEX_BITS(6),
    .FIFO_DEPTH(8),
    .PC_WIDTH  (32)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .lookupValid_i (lookupValid_i),
    .fetchPc_i     (fetchPc_i),
    .lookupReady_o (lookupReady_o),
    .predTaken_o   (predTaken_o),
    .resolveValid_i(resolveValid_i),
    .brTaken_i     (brTaken_i),
    .flush_i       (flush_i),
    .mispredict_o  (mispredict_o),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookupValid_i = 1'b1;
    fetchPc_i     = pc;
    step();
    lookupValid_i = 1'b0;
  endtask

  task automatic do_resolve(input logic taken);
    resolveValid_i = 1'b1;
    brTaken_i      = taken;
    step();
    resolveValid_i = 1'b0;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    fetchPc_i = pc;
    #1;
    chk(tag, {31'd0, predTaken_o}, {31'd0, exp});
  endtask

  initial begin
    reset_i        = 1'b1;
    lookupValid_i  = 1'b0;
    fetchPc_i      = '0;
    resolveValid_i = 1'b0;
    brTaken_i      = 1'b0;
    flush_i        = 1'b0;
    step();
    step();
    reset_i = 1'b0;

    chk("rst_outstanding", {28'd0, outstanding_o}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict_o}, 32'd0);
    chk("rst_ready", {31'd0, lookupReady_o}, 32'd1);
    pred_at("rst_pred", 32'h40, 1'b1);

`ifndef BPT_GSHARE_EN
    // Counter walk on index 16 (PC 0x40)
    do_lookup(32'h40);
    chk("first_push_occ", {28'd0, outstanding_o}, 32'd1);
    do_resolve(1'b0);
    chk("first_mispredict", {31'd0, mispredict_o}, 32'd1);
    chk("first_pop_occ", {28'd0, outstanding_o}, 32'd0);
    pred_at("ctr01_pred", 32'h40, 1'b1);
    step();
    chk("mispredict_pulse_clears", {31'd0, mispredict_o}, 32'd0);

    do_lookup(32'h40); do_resolve(1'b0);           // 01 -> 10
    pred_at("ctr10_pred", 32'h40, 1'b0);
    do_lookup(32'h40); do_resolve(1'b0);           // 10 -> 11, predicted NT
    chk("nt_correct_no_mp", {31'd0, mispredict_o}, 32'd0);
    do_lookup(32'h40); do_resolve(1'b0);           // saturates at 11
    pred_at("ctr11_pred", 32'h40, 1'b0);
    do_lookup(32'h40); do_resolve(1'b1);           // 11 -> 10
    pred_at("ctr10b_pred", 32'h40, 1'b0);
    do_lookup(32'h40); do_resolve(1'b1);           // 10 -> 01
    chk("t_after_nt_mp", {31'd0, mispredict_o}, 32'd1);
    pred_at("ctr01b_pred", 32'h40, 1'b1);
    do_lookup(32'h40); do_resolve(1'b1);           // 01 -> 00
    do_lookup(32'h40); do_resolve(1'b1);           // stays 00
    chk("t_correct_no_mp", {31'd0, mispredict_o}, 32'd0);
    do_lookup(32'h40); do_resolve(1'b0);           // 00 -> 01 (not 10 if saturated)
    pred_at("sat00_then_nt_pred", 32'h40, 1'b1);

    // Fill the FIFO
    for (int i = 0; i < 8; i++) do_lookup(32'h80);
    chk("full_ready", {31'd0, lookupReady_o}, 32'd0);
    chk("full_occ", {28'd0, outstanding_o}, 32'd8);
    do_lookup(32'h80);
    chk("full_drop_occ", {28'd0, outstanding_o}, 32'd8);
    lookupValid_i  = 1'b1;
    fetchPc_i      = 32'h80;
    resolveValid_i = 1'b1;
    brTaken_i      = 1'b1;
    #1;
    chk("full_ready_with_resolve", {31'd0, lookupReady_o}, 32'd1);
    step();
    lookupValid_i  = 1'b0;
    resolveValid_i = 1'b0;
    chk("full_push_pop_occ", {28'd0, outstanding_o}, 32'd8);
    chk("full_push_pop_mp", {31'd0, mispredict_o}, 32'd0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_only_occ", {28'd0, outstanding_o}, 32'd0);

    // Flush with simultaneous resolve and lookup
    do_lookup(32'h10);
    do_lookup(32'h14);
    do_lookup(32'h18);
    flush_i        = 1'b1;
    resolveValid_i = 1'b1;
    brTaken_i      = 1'b0;
    lookupValid_i  = 1'b1;
    fetchPc_i      = 32'h1C;
    step();
    flush_i        = 1'b0;
    resolveValid_i = 1'b0;
    lookupValid_i  = 1'b0;
    chk("flush_resolve_mp", {31'd0, mispredict_o}, 32'd1);
    chk("flush_resolve_occ", {28'd0, outstanding_o}, 32'd0);
    do_lookup(32'h10); do_resolve(1'b0);           // index 4: 01 -> 10
    chk("post_flush_mp", {31'd0, mispredict_o}, 32'd1);
    pred_at("head_ctr_updated", 32'h10, 1'b0);
    do_lookup(32'h14); do_resolve(1'b0);           // index 5: 00 -> 01
    pred_at("non_head_ctr_kept", 32'h14, 1'b1);

    // Resolve with nothing outstanding
    do_resolve(1'b0);
    chk("empty_resolve_mp", {31'd0, mispredict_o}, 32'd0);
    chk("empty_resolve_occ", {28'd0, outstanding_o}, 32'd0);

    // Lookup and resolve to the same index in one cycle (index 4 at 10)
    do_lookup(32'h10);
    lookupValid_i  = 1'b1;
    fetchPc_i      = 32'h10;
    resolveValid_i = 1'b1;
    brTaken_i      = 1'b1;
    #1;
    chk("same_idx_pre_update_pred", {31'd0, predTaken_o}, 32'd0);
    step();
    lookupValid_i  = 1'b0;
    resolveValid_i = 1'b0;
    chk("same_idx_occ", {28'd0, outstanding_o}, 32'd1);
    chk("same_idx_mp", {31'd0, mispredict_o}, 32'd1);
    pred_at("same_idx_post_pred", 32'h10, 1'b1);
    do_resolve(1'b1);                              // stored pred was 0
    chk("same_idx_stored_pred_mp", {31'd0, mispredict_o}, 32'd1);
    chk("same_idx_drain_occ", {28'd0, outstanding_o}, 32'd0);
`else
    // Build GHR = 0b11 with two taken resolves at PC 0
    do_lookup(32'h0); do_resolve(1'b1);
    do_lookup(32'h0); do_resolve(1'b1);
    pred_at("gs_pc0c_pred", 32'h0C, 1'b1);
    do_lookup(32'h0C); do_resolve(1'b0);           // entry 0: 00 -> 01, GHR=6
    chk("gs_mp1", {31'd0, mispredict_o}, 32'd1);
    chk("gs_occ", {28'd0, outstanding_o}, 32'd0);
    pred_at("gs_pc18_pred", 32'h18, 1'b1);
    do_lookup(32'h18); do_resolve(1'b0);           // entry 0: 01 -> 10, GHR=12
    chk("gs_mp2", {31'd0, mispredict_o}, 32'd1);
    pred_at("gs_entry0_pred", 32'h30, 1'b0);
    pred_at("gs_entry15_pred", 32'h0C, 1'b1);
    pred_at("gs_entry3_untouched", 32'h3C, 1'b1);  // 15 ^ 12 = 3
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
